// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access pipeline stage behind the execute ALU.
// It runs the data-memory req/ack transaction, aligns store byte lanes, and
// extends load data before it issues a one-cycle writeback packet.
// Byte order is big-endian: offset 0 is lane [31:24].
// Optional feature: define MEM_TIMEOUT_EN to abort an ACCESS after
// TIMEOUT_CYCLES cycles without ack. The abort gives a writeback with no
// register write and an exception pulse.
// Opcode values mirror the isa_codes.v macros (MIPS primary opcodes).
module mem_access_stage #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic             w_clk,
  input  logic             w_reset_n,
  input  logic             w_valid_in,
  output logic             w_ready_out,
  input  logic [5:0]       w_op_code_6,
  input  logic             w_mem_op,
  input  logic [WIDTH-1:0] w_alu_result_x,
  input  logic [WIDTH-1:0] w_store_data_x,
  input  logic [4:0]       w_dest_reg_5,
  input  logic             w_reg_write,
  output logic             w_dmem_req,
  output logic             w_dmem_we,
  output logic [WIDTH-1:0] w_dmem_addr_x,
  output logic [3:0]       w_dmem_be_4,
  output logic [WIDTH-1:0] w_dmem_wdata_x,
  input  logic             w_dmem_ack,
  input  logic [WIDTH-1:0] w_dmem_rdata_x,
  output logic             w_wb_valid,
  output logic             w_wb_reg_write,
  output logic [4:0]       w_wb_dest_5,
  output logic [WIDTH-1:0] w_wb_data_x,
  output logic             w_exception
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_LW   = 2'd1;
  localparam logic [1:0] K_LB   = 2'd2;
  localparam logic [1:0] K_LBU  = 2'd3;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_WB = 2'd2} state_t;

  // Unsupported configurations elaborate this marker block; supported ones add no logic.
  if (WIDTH != 32 || TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 256) begin : g_unsupported_config
  end

  state_t r_state, w_next_state;

  logic             r_ready, r_req, r_we, r_wb_valid, r_wb_rw, r_exc;
  logic [WIDTH-1:0] r_addr, r_wdata, r_wb_data;
  logic [3:0]       r_be;
  logic [4:0]       r_wb_dest;
  logic [1:0]       r_kind, r_lane;
  logic [4:0]       r_dest;
  logic             r_rw;

  logic             nx_ready, nx_req, nx_we, nx_wb_valid, nx_wb_rw, nx_exc;
  logic [WIDTH-1:0] nx_addr, nx_wdata, nx_wb_data;
  logic [3:0]       nx_be;
  logic [4:0]       nx_wb_dest;
  logic [1:0]       nx_kind, nx_lane;
  logic [4:0]       nx_dest;
  logic             nx_rw;

  logic             w_is_lw, w_is_sw, w_is_lb, w_is_lbu, w_is_sb;
  logic             w_mem_access, w_misalign, w_is_store, w_accept, w_timeout;
  logic [3:0]       w_be;
  logic [WIDTH-1:0] w_wdata, w_load_data;
  logic [1:0]       w_kind;
  logic [7:0]       w_byte;

  // Opcode decode and lane formatting of the incoming request.
  assign w_is_lw      = (w_op_code_6 == OP_LW);
  assign w_is_sw      = (w_op_code_6 == OP_SW);
  assign w_is_lb      = (w_op_code_6 == OP_LB);
  assign w_is_lbu     = (w_op_code_6 == OP_LBU);
  assign w_is_sb      = (w_op_code_6 == OP_SB);
  assign w_mem_access = w_mem_op && (w_is_lw || w_is_sw || w_is_lb || w_is_lbu || w_is_sb);
  assign w_misalign   = w_mem_access && (w_is_lw || w_is_sw) && (w_alu_result_x[1:0] != 2'b00);
  assign w_is_store   = w_is_sw || w_is_sb;
  assign w_be         = (w_is_lw || w_is_sw) ? 4'b1111 : (4'b1000 >> w_alu_result_x[1:0]);
  assign w_wdata      = w_is_sb ? {4{w_store_data_x[7:0]}} :
                        w_is_sw ? w_store_data_x : {WIDTH{1'b0}};
  assign w_kind       = !w_mem_access ? K_NONE :
                        w_is_lw       ? K_LW   :
                        w_is_lb       ? K_LB   :
                        w_is_lbu      ? K_LBU  : K_NONE;
  assign w_accept     = w_valid_in && r_ready;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] r_wait_cnt;

  // Counts cycles spent waiting for ack; cleared outside ACCESS.
  always_ff @(posedge w_clk or negedge w_reset_n) begin
    if (!w_reset_n)               r_wait_cnt <= 8'd0;
    else if (r_state == S_ACCESS) r_wait_cnt <= r_wait_cnt + 8'd1;
    else                          r_wait_cnt <= 8'd0;
  end

  assign w_timeout = (r_state == S_ACCESS) && !w_dmem_ack && (r_wait_cnt == TIMEOUT_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // Byte lane select and sign/zero extension of returning load data.
  always_comb begin
    w_byte = 8'h00;
    case (r_lane)
      2'd0:    w_byte = w_dmem_rdata_x[31:24];
      2'd1:    w_byte = w_dmem_rdata_x[23:16];
      2'd2:    w_byte = w_dmem_rdata_x[15:8];
      default: w_byte = w_dmem_rdata_x[7:0];
    endcase
    case (r_kind)
      K_LW:    w_load_data = w_dmem_rdata_x;
      K_LB:    w_load_data = {{24{w_byte[7]}}, w_byte};
      K_LBU:   w_load_data = {24'h000000, w_byte};
      default: w_load_data = {WIDTH{1'b0}};
    endcase
  end

  // State register.
  always_ff @(posedge w_clk or negedge w_reset_n) begin
    if (!w_reset_n) r_state <= S_IDLE;
    else            r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next_state = (w_mem_access && !w_misalign) ? S_ACCESS : S_WB;
      S_ACCESS: if (w_dmem_ack || w_timeout) w_next_state = S_WB;
      S_WB:     w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and the captured request context.
  always_comb begin
    nx_ready    = 1'b0;
    nx_req      = 1'b0;
    nx_we       = 1'b0;
    nx_addr     = {WIDTH{1'b0}};
    nx_be       = 4'b0000;
    nx_wdata    = {WIDTH{1'b0}};
    nx_wb_valid = 1'b0;
    nx_wb_rw    = 1'b0;
    nx_wb_dest  = 5'd0;
    nx_wb_data  = {WIDTH{1'b0}};
    nx_exc      = 1'b0;
    nx_kind     = r_kind;
    nx_lane     = r_lane;
    nx_dest     = r_dest;
    nx_rw       = r_rw;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          nx_kind = w_kind;
          nx_lane = w_alu_result_x[1:0];
          nx_dest = w_dest_reg_5;
          nx_rw   = w_reg_write;
          if (w_next_state == S_ACCESS) begin
            nx_req   = 1'b1;
            nx_we    = w_is_store;
            nx_addr  = {w_alu_result_x[WIDTH-1:2], 2'b00};
            nx_be    = w_be;
            nx_wdata = w_wdata;
          end else begin
            nx_wb_valid = 1'b1;
            nx_wb_dest  = w_dest_reg_5;
            nx_wb_rw    = w_reg_write && !w_misalign;
            nx_wb_data  = w_misalign ? {WIDTH{1'b0}} : w_alu_result_x;
            nx_exc      = w_misalign;
          end
        end else begin
          nx_ready = 1'b1;
        end
      end
      S_ACCESS: begin
        if (w_next_state == S_ACCESS) begin
          nx_req   = r_req;
          nx_we    = r_we;
          nx_addr  = r_addr;
          nx_be    = r_be;
          nx_wdata = r_wdata;
        end else begin
          nx_wb_valid = 1'b1;
          nx_wb_dest  = r_dest;
          if (w_dmem_ack) begin
            nx_wb_rw   = r_rw && (r_kind != K_NONE);
            nx_wb_data = w_load_data;
          end else begin
            nx_exc = 1'b1;
          end
        end
      end
      S_WB:    nx_ready = 1'b1;
      default: nx_ready = 1'b0;
    endcase
  end

  // Output and context registers.
  always_ff @(posedge w_clk or negedge w_reset_n) begin
    if (!w_reset_n) begin
      r_ready    <= 1'b0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= {WIDTH{1'b0}};
      r_be       <= 4'b0000;
      r_wdata    <= {WIDTH{1'b0}};
      r_wb_valid <= 1'b0;
      r_wb_rw    <= 1'b0;
      r_wb_dest  <= 5'd0;
      r_wb_data  <= {WIDTH{1'b0}};
      r_exc      <= 1'b0;
      r_kind     <= K_NONE;
      r_lane     <= 2'd0;
      r_dest     <= 5'd0;
      r_rw       <= 1'b0;
    end else begin
      r_ready    <= nx_ready;
      r_req      <= nx_req;
      r_we       <= nx_we;
      r_addr     <= nx_addr;
      r_be       <= nx_be;
      r_wdata    <= nx_wdata;
      r_wb_valid <= nx_wb_valid;
      r_wb_rw    <= nx_wb_rw;
      r_wb_dest  <= nx_wb_dest;
      r_wb_data  <= nx_wb_data;
      r_exc      <= nx_exc;
      r_kind     <= nx_kind;
      r_lane     <= nx_lane;
      r_dest     <= nx_dest;
      r_rw       <= nx_rw;
    end
  end

  assign w_ready_out    = r_ready;
  assign w_dmem_req     = r_req;
  assign w_dmem_we      = r_we;
  assign w_dmem_addr_x  = r_addr;
  assign w_dmem_be_4    = r_be;
  assign w_dmem_wdata_x = r_wdata;
  assign w_wb_valid     = r_wb_valid;
  assign w_wb_reg_write = r_wb_rw;
  assign w_wb_dest_5    = r_wb_dest;
  assign w_wb_data_x    = r_wb_data;
  assign w_exception    = r_exc;

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access pipeline stage placed directly downstream of the execute ALU. It accepts one ALU result per handshake: the effective address for LW/LB/LBU/SW/SB, or the final value for all other ops. It runs the data-memory request/acknowledge transaction, aligns store byte lanes, and sign- or zero-extends load data. It then presents a single-cycle writeback packet to the register-file stage.

## Interface
- WIDTH, 32, datapath width; only 32 is supported.
- TIMEOUT_CYCLES, 16, cycles to wait for w_dmem_ack before abort. Used only when MEM_TIMEOUT_EN is defined.

- w_clk  in  1  rising-edge clock.
- w_reset_n  in  1  reset; asynchronous, active-low.
- w_valid_in  in  1  execute result valid.
- w_ready_out  out  1  stage can accept; high only in IDLE with reset deasserted.
- w_op_code_6  in  6  opcode/function, using the isa_codes.v macros (`LW, `SW, `LB, `LBU, `SB, `LUI, ...).
- w_mem_op  in  1  op is a memory-class op.
- w_alu_result_x  in  WIDTH  ALU output: address or result.
- w_store_data_x  in  WIDTH  rt value for stores.
- w_dest_reg_5  in  5  destination register.
- w_reg_write  in  1  op writes the register file.
- w_dmem_req  out  1  memory request.
- w_dmem_we  out  1  1 = write.
- w_dmem_addr_x  out  WIDTH  word address; bits [1:0] are always 0.
- w_dmem_be_4  out  4  byte enables; bit 3 = byte lane [31:24].
- w_dmem_wdata_x  out  WIDTH  lane-aligned write data.
- w_dmem_ack  in  1  memory done; rdata valid in the same cycle.
- w_dmem_rdata_x  in  WIDTH  read data.
- w_wb_valid  out  1  writeback packet valid for one cycle.
- w_wb_reg_write  out  1  writeback enable.
- w_wb_dest_5  out  5  writeback register.
- w_wb_data_x  out  WIDTH  writeback value.
- w_exception  out  1  one-cycle pulse on misaligned access (or timeout, when enabled).

## Operation
- Byte order is big-endian: byte offset 0 is lane [31:24], offset 3 is lane [7:0].
- States:
  - IDLE: accept when w_valid_in && w_ready_out; capture all inputs.
  - ACCESS: w_dmem_req held high with stable address, write-enable, byte-enable and data until w_dmem_ack.
  - WB: drive the writeback packet for one cycle, then return to IDLE.
- Non-memory op, or w_mem_op with `LUI:
  - IDLE → WB.
  - w_wb_data_x = captured w_alu_result_x; w_wb_reg_write = captured w_reg_write.
- LW/SW:
  - addr[1:0] != 0 is misaligned: no request, IDLE → WB with w_wb_reg_write=0, and w_exception pulses in the WB cycle.
  - Aligned: be=4'b1111.
- LB/LBU/SB: any alignment is legal.
  - be = one-hot lane selected by addr[1:0].
  - SB write data: rt[7:0] replicated into all four lanes.
- Loads:
  - On ack, select the lane.
  - LB sign-extends bit 7 of the byte; LBU zero-extends.
  - LW passes the word.
  - Result is registered into w_wb_data_x.
- Stores: WB cycle with w_wb_reg_write=0 and w_wb_data_x=0.
- Writes to register 0: passed through unchanged; the register file ignores them.
- Unknown opcode with w_mem_op=1: treated as non-memory pass-through.

## Timing
- Reset values: every output 0, including w_ready_out. State = IDLE. Reset takes effect immediately and asynchronously.
- Accept edge T:
  - Non-memory op: w_wb_valid high in cycle T+1.
  - Memory op: w_dmem_req high from cycle T+1.
- ack sampled high in cycle T+1+k (k ≥ 0):
  - w_dmem_req is low from T+2+k.
  - w_wb_valid is high in cycle T+2+k.
- Throughput:
  - Non-memory ops: one accept every 2 cycles (w_ready_out is low in WB).
  - Memory ops: one accept every k+3 cycles.
- w_dmem_ack outside ACCESS is ignored.
- Reset asserted in ACCESS: request drops immediately; no writeback is produced.
- No backpressure from writeback; w_wb_valid is always a single-cycle pulse.

## Configuration
- MEM_TIMEOUT_EN defined:
  - An 8-bit counter runs in ACCESS.
  - If TIMEOUT_CYCLES cycles pass without ack, go to WB with w_wb_reg_write=0 and pulse w_exception.
  - A late ack after abort is ignored.
- MEM_TIMEOUT_EN undefined: no counter; ACCESS waits for ack indefinitely.

## Test plan
- Reset: w_reset_n low for 3 cycles → every output 0. After release, w_ready_out=1.
- ADDU: result 32'h0000_0042, dest 5, reg_write=1 → cycle T+1 shows wb_valid=1, dest=5, data=32'h42, and w_dmem_req never asserts.
- LB at addr 32'h1003; memory returns 32'h1122_3380 with ack after 2 wait cycles → addr=32'h1000, be=4'b0001, wb_data=32'hFFFF_FF80. The same access with LBU → 32'h0000_0080.
- SB at addr 32'h2001 with rt=32'hDEAD_BEA5 → we=1, be=4'b0100, wdata=32'hA5A5_A5A5; WB has reg_write=0.
- LW at addr 32'h3002 → no request; wb_valid=1 with reg_write=0; w_exception pulses for one cycle.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=16: SW and ack never arrives → req drops after 16 cycles and w_exception pulses. Reset asserted mid-ACCESS in a separate run → req=0 immediately and no wb_valid.
